shift_count_register: RTL and testbench
=======================================

SHIFT_COUNT_REGISTER -- requirements
Module: shift_count_register

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (≥2).
REQ-002 Parameter RESET_VALUE, default 0, value of data_out after reset, WIDTH bits.
REQ-003 Parameter SATURATE, default 0: 0 = increment/decrement wrap around; 1 = increment/decrement clamp at all-ones/zero.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  WIDTH  parallel load value.
REQ-007 op  input  3  operation select, sampled each rising edge.
REQ-008 carry_in  input  1  bit shifted into rotate operations.
REQ-009 data_out  output  WIDTH  current register value, driven directly from the state register.
REQ-010 carry_out  output  1  registered carry/borrow/shifted-out bit.
REQ-011 zero  output  1  data_out == 0 (see Configuration).
REQ-012 negative  output  1  data_out[WIDTH-1] (see Configuration).

Function
REQ-013 op encoding, applied at each rising edge, result visible one cycle later: 000 HOLD, 001 LOAD, 010 INC, 011 DEC, 100 SHL, 101 SHR, 110 ROL, 111 ROR.
REQ-014 HOLD: value and carry_out unchanged.
REQ-015 LOAD: value <= data_in; carry_out unchanged.
REQ-016 INC, SATURATE=0: value <= value+1 mod 2^WIDTH; carry_out <= 1 if value was all-ones, else 0.
REQ-017 DEC, SATURATE=0: value <= value-1 mod 2^WIDTH; carry_out <= 1 (borrow) if value was 0, else 0.
REQ-018 INC, SATURATE=1: at all-ones, value held and carry_out <= 1; otherwise as REQ-016.
REQ-019 DEC, SATURATE=1: at 0, value held and carry_out <= 1; otherwise as REQ-017.
REQ-020 SHL: value <= {value[WIDTH-2:0],0}; carry_out <= old value[WIDTH-1].
REQ-021 SHR: value <= {0,value[WIDTH-1:1]}; carry_out <= old value[0].
REQ-022 ROL: value <= {value[WIDTH-2:0],carry_in}; carry_out <= old value[WIDTH-1].
REQ-023 ROR: value <= {carry_in,value[WIDTH-1:1]}; carry_out <= old value[0].
REQ-024 All operations use the pre-edge value; no combinational path from data_in, op or carry_in to data_out or carry_out.
REQ-025 Unknown/X op is not defined behaviour; the bench keeps op driven.

Reset
REQ-026 reset asserted: data_out = RESET_VALUE and carry_out = 0 immediately, independent of clk.
REQ-027 reset overrides any op, including a LOAD/INC in the same cycle as deassertion edge being ignored while reset high.
REQ-028 First operation after reset deassertion takes effect on the first rising edge with reset low.

Configuration
REQ-029 Macro SHIFT_COUNT_REGISTER_FLAGS_EN defined: zero and negative are combinational functions of data_out per REQ-011/REQ-012, including during reset.
REQ-030 Macro undefined: zero and negative ports remain present and are tied to 0; no flag logic synthesised.

Verification
REQ-031 WIDTH=8: reset high -> data_out=0x00, carry_out=0; LOAD 0xA5 -> 0xA5, negative=1 (FLAGS_EN).
REQ-032 WIDTH=8, SATURATE=0: LOAD 0xFF, INC -> 0x00, carry_out=1, zero=1; DEC -> 0xFF, carry_out=1.
REQ-033 WIDTH=8, SATURATE=1: LOAD 0xFE, INC, INC -> 0xFF carry_out=0, then 0xFF carry_out=1; LOAD 0x00, DEC -> 0x00, carry_out=1.
REQ-034 LOAD 0x81, ROL carry_in=0 -> 0x02 carry_out=1; ROR carry_in=1 -> 0x81 carry_out=0; SHR -> 0x40 carry_out=1.
REQ-035 WIDTH=16, RESET_VALUE=0x01FF: INC four cycles, assert reset mid-clock-period -> data_out=0x01FF immediately without a clock edge; HOLD then -> unchanged.
REQ-036 Build without SHIFT_COUNT_REGISTER_FLAGS_EN: LOAD 0x00 and 0x80 -> zero=0, negative=0 throughout.

Source files
------------

// File: rtl/shift_count_register.sv
// rtl/shift_count_register.sv - shift/count register with load, inc/dec, shifts and rotates
// Optional flag outputs enabled by defining SHIFT_COUNT_REGISTER_FLAGS_EN.
module shift_count_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SATURATE    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       op,
    input  logic             carry_in,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out,
    output logic             zero,
    output logic             negative
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_ROR  = 3'b111
    } op_e;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d;
    logic             at_max, at_min;

    assign at_max = (value_q == ALL_ONES);
    assign at_min = (value_q == '0);

    always_comb begin
        value_d = value_q;
        carry_d = carry_q;
        case (op_e'(op))
            OP_HOLD: ;
            OP_LOAD: value_d = data_in;
            OP_INC: begin
                carry_d = at_max;
                // Saturating mode flags the clamp through carry_out but keeps the value.
                if (!(SATURATE != 0 && at_max)) begin
                    value_d = value_q + ONE;
                end
            end
            OP_DEC: begin
                carry_d = at_min;
                if (!(SATURATE != 0 && at_min)) begin
                    value_d = value_q - ONE;
                end
            end
            OP_SHL: begin
                value_d = {value_q[WIDTH-2:0], 1'b0};
                carry_d = value_q[WIDTH-1];
            end
            OP_SHR: begin
                value_d = {1'b0, value_q[WIDTH-1:1]};
                carry_d = value_q[0];
            end
            OP_ROL: begin
                value_d = {value_q[WIDTH-2:0], carry_in};
                carry_d = value_q[WIDTH-1];
            end
            OP_ROR: begin
                value_d = {carry_in, value_q[WIDTH-1:1]};
                carry_d = value_q[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= RESET_VALUE;
            carry_q <= 1'b0;
        end else begin
            value_q <= value_d;
            carry_q <= carry_d;
        end
    end

    assign data_out  = value_q;
    assign carry_out = carry_q;

`ifdef SHIFT_COUNT_REGISTER_FLAGS_EN
    assign zero     = (value_q == '0);
    assign negative = value_q[WIDTH-1];
`else
    assign zero     = 1'b0;
    assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_shift_count_register.sv
// tb/tb_shift_count_register.sv - directed self-checking bench for shift_count_register
module tb_shift_count_register;

`ifdef SHIFT_COUNT_REGISTER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, INC = 3'b010, DEC = 3'b011;
    localparam logic [2:0] SHL = 3'b100, SHR = 3'b101, ROL = 3'b110, ROR = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rst16 = 1'b0;
    logic [7:0]  din8 = '0;
    logic [2:0]  op8 = HOLD;
    logic        cin8 = 1'b0;
    logic [15:0] din16 = '0;
    logic [2:0]  op16 = HOLD;
    logic        cin16 = 1'b0;

    logic [7:0]  q_w, q_s;
    logic        c_w, c_s, z_w, z_s, n_w, n_s;
    logic [15:0] q16;
    logic        c16, z16, n16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shift_count_register #(.WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .data_in(din8), .op(op8), .carry_in(cin8),
        .data_out(q_w), .carry_out(c_w), .zero(z_w), .negative(n_w)
    );

    shift_count_register #(.WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .data_in(din8), .op(op8), .carry_in(cin8),
        .data_out(q_s), .carry_out(c_s), .zero(z_s), .negative(n_s)
    );

    shift_count_register #(.WIDTH(16), .RESET_VALUE(16'h01FF), .SATURATE(0)) u_w16 (
        .clk(clk), .reset(rst16), .data_in(din16), .op(op16), .carry_in(cin16),
        .data_out(q16), .carry_out(c16), .zero(z16), .negative(n16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [7:0] v, input logic c);
        chk({tag, ".wrap.data"}, 32'(q_w), 32'(v));
        chk({tag, ".wrap.carry"}, 32'(c_w), 32'(c));
        chk({tag, ".wrap.zero"}, 32'(z_w), 32'(FLAGS && (v == 8'h00)));
        chk({tag, ".wrap.neg"}, 32'(n_w), 32'(FLAGS && v[7]));
    endtask

    task automatic chk_s(input string tag, input logic [7:0] v, input logic c);
        chk({tag, ".sat.data"}, 32'(q_s), 32'(v));
        chk({tag, ".sat.carry"}, 32'(c_s), 32'(c));
        chk({tag, ".sat.zero"}, 32'(z_s), 32'(FLAGS && (v == 8'h00)));
        chk({tag, ".sat.neg"}, 32'(n_s), 32'(FLAGS && v[7]));
    endtask

    task automatic step8(input logic [2:0] op, input logic [7:0] d, input logic ci);
        @(negedge clk);
        op8  = op;
        din8 = d;
        cin8 = ci;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Asynchronous reset before any clock edge has occurred
        #1 reset = 1'b1; rst16 = 1'b1;
        #1;
        chk_w("reset", 8'h00, 1'b0);
        chk_s("reset", 8'h00, 1'b0);
        chk("reset.w16.data", 32'(q16), 32'h01FF);

        // Operations are ignored while reset is held
        step8(LOAD, 8'h5A, 1'b0);
        chk_w("load_in_reset", 8'h00, 1'b0);

        @(negedge clk);
        reset = 1'b0; rst16 = 1'b0;
        op8 = LOAD; din8 = 8'hA5;
        @(posedge clk);
        #1;
        chk_w("load_a5", 8'hA5, 1'b0);
        step8(HOLD, 8'h11, 1'b1);
        chk_w("hold", 8'hA5, 1'b0);

        step8(LOAD, 8'hFF, 1'b0);
        step8(INC, 8'h00, 1'b0);
        chk_w("inc_ff", 8'h00, 1'b1);
        chk_s("inc_ff", 8'hFF, 1'b1);
        step8(DEC, 8'h00, 1'b0);
        chk_w("dec_00", 8'hFF, 1'b1);
        chk_s("dec_ff", 8'hFE, 1'b0);

        step8(LOAD, 8'hFE, 1'b0);
        chk_w("load_keeps_carry", 8'hFE, 1'b1);
        step8(INC, 8'h00, 1'b0);
        chk_w("inc_fe", 8'hFF, 1'b0);
        chk_s("inc_fe", 8'hFF, 1'b0);
        step8(INC, 8'h00, 1'b0);
        chk_w("inc_ff2", 8'h00, 1'b1);
        chk_s("inc_clamp", 8'hFF, 1'b1);

        step8(LOAD, 8'h00, 1'b0);
        step8(DEC, 8'h00, 1'b0);
        chk_w("dec_wrap", 8'hFF, 1'b1);
        chk_s("dec_clamp", 8'h00, 1'b1);

        step8(LOAD, 8'h01, 1'b0);
        step8(DEC, 8'h00, 1'b0);
        chk_w("dec_01", 8'h00, 1'b0);
        chk_s("dec_01", 8'h00, 1'b0);

        step8(LOAD, 8'h81, 1'b0);
        step8(ROL, 8'h00, 1'b0);
        chk_w("rol", 8'h02, 1'b1);
        step8(ROR, 8'h00, 1'b1);
        chk_w("ror", 8'h81, 1'b0);
        step8(SHR, 8'h00, 1'b1);
        chk_w("shr", 8'h40, 1'b1);
        step8(SHL, 8'h00, 1'b1);
        chk_w("shl", 8'h80, 1'b0);
        step8(SHL, 8'h00, 1'b1);
        chk_w("shl_out", 8'h00, 1'b1);
        chk_s("shl_out", 8'h00, 1'b1);

        // 16-bit instance: count, then reset in mid-period with no clock edge
        @(negedge clk);
        op16 = INC;
        repeat (4) @(posedge clk);
        #1;
        chk("w16.inc4.data", 32'(q16), 32'h0203);
        chk("w16.inc4.carry", 32'(c16), 32'h0);
        #2 rst16 = 1'b1;
        #1;
        chk("w16.async.data", 32'(q16), 32'h01FF);
        chk("w16.async.carry", 32'(c16), 32'h0);
        chk("w16.zero", 32'(z16), 32'h0);
        chk("w16.neg", 32'(n16), 32'h0);
        @(negedge clk);
        rst16 = 1'b0;
        op16 = HOLD;
        @(posedge clk);
        #1;
        chk("w16.hold.data", 32'(q16), 32'h01FF);
        chk("w16.hold.carry", 32'(c16), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
